i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Parameters
REQ-001 The block SHALL have parameter WR_GAP_CYC, default 250000, setting the EEPROM internal write-cycle hold-off in clk cycles (5 ms at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1000000, setting the maximum clk cycles to wait for controller completion.

Interface
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rstn  in  1  synchronous, active-high reset (asserted = 1, sampled on clk).
REQ-005 req  in  2  per-requester transaction request; bit0 = requester 0, bit1 = requester 1.
REQ-006 req_wr  in  2  per-requester direction; 1 = byte write, 0 = byte read.
REQ-007 req_addr  in  32  per-requester EEPROM address; [15:0] = req0, [31:16] = req1.
REQ-008 req_wdata  in  16  per-requester write byte; [7:0] = req0, [15:8] = req1.
REQ-009 gnt  out  2  one-hot; high for the requester owning the bus.
REQ-010 done  out  2  one-cycle pulse on successful completion for the owner.
REQ-011 err  out  2  one-cycle pulse on timeout for the owner.
REQ-012 rdata  out  8  last read byte; updated only on read completion.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 i2c_start_flag  out  1  one-cycle start pulse to the I2C byte controller.
REQ-015 i2c_wr_flag, i2c_rd_flag  out  1 each  direction levels to the controller; mutually exclusive.
REQ-016 i2c_addr  out  16, i2c_data_wr  out  8  latched transaction fields.
REQ-017 i2c_done  in  1  controller completion pulse; i2c_data_rd valid in the same cycle.
REQ-018 i2c_data_rd  in  8  read byte from the controller.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and GAP.
REQ-020 Requesters SHALL hold req, req_wr, req_addr and req_wdata stable from assertion until done or err; the block samples fields only in IDLE.
REQ-021 In IDLE with req != 0 at cycle N, the block SHALL latch the winner's fields, set gnt and i2c_start_flag at N+1 (ISSUE), and enter WAIT at N+2.
REQ-022 Arbitration SHALL be round-robin: a single request wins; if both bits are set, the requester not served last wins; after reset, requester 0 counts as last served, so requester 1 wins the first tie.
REQ-023 i2c_start_flag SHALL be high only in the ISSUE cycle.
REQ-024 i2c_wr_flag/i2c_rd_flag, i2c_addr and i2c_data_wr SHALL be held constant from ISSUE through WAIT and be 0 otherwise.
REQ-025 In WAIT, i2c_done SHALL pulse done[owner] in the next cycle and clear gnt in that same cycle.
REQ-026 On read completion, rdata SHALL take i2c_data_rd in the same cycle that done pulses.
REQ-027 A completed write SHALL enter GAP for exactly WR_GAP_CYC cycles, then return to IDLE; a completed read SHALL return to IDLE directly.
REQ-028 A WAIT counter SHALL reach TIMEOUT_CYC-1 without i2c_done; the block SHALL then pulse err[owner] instead of done, clear gnt and enter GAP.
REQ-029 i2c_done arriving in IDLE, ISSUE or GAP SHALL be ignored.
REQ-030 Deassertion of req by the owner mid-transaction SHALL be ignored; the transaction completes and done/err still pulses.
REQ-031 Requests arriving during ISSUE, WAIT or GAP SHALL be held pending with no loss and arbitrated on the next IDLE cycle.
REQ-032 Counters SHALL be wide enough for max(WR_GAP_CYC, TIMEOUT_CYC) and SHALL not wrap.

Reset
REQ-033 On rstn=1 the block SHALL set state IDLE, clear gnt/done/err/busy/i2c_start_flag/i2c_wr_flag/i2c_rd_flag, set i2c_addr/i2c_data_wr/rdata to 0, clear all counters and set the last-served pointer to 0.
REQ-034 Reset asserted mid-transaction SHALL abort with no done/err pulse; the outputs above SHALL hold reset values in the cycle after rstn is sampled high.

Verification
REQ-035 Single read: req=01, req_wr=00, addr0=0x0010; i2c_done with i2c_data_rd=0xA5 after 20 cycles -> one start pulse, rd_flag high, done=01 and rdata=0xA5 in the same cycle, IDLE directly.
REQ-036 Single write: req=10, req_wr=10, addr1=0x0123, wdata1=0x5C -> i2c_addr=0x0123, i2c_data_wr=0x5C, wr_flag high; done=10, then busy high for WR_GAP_CYC cycles.
REQ-037 Tie: req=11 out of reset -> order req1, req0, req1 across three rounds, with no overlapping gnt.
REQ-038 Timeout: TIMEOUT_CYC=100, no i2c_done -> err pulses at cycle 100 of WAIT, done stays 0, GAP entered.
REQ-039 Reset mid-WAIT: rstn=1 pulse during WAIT -> no done/err pulse, all outputs 0 next cycle, a new request then serviced normally.
REQ-040 Spurious i2c_done in IDLE and during GAP -> no done pulse and no state change.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Bundle between the two EEPROM requesters, the arbiter and the I2C byte controller.
// slave = arbiter view, master = environment (requesters + controller) view.
interface i2c_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  req_wr;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic        i2c_start_flag;
    logic        i2c_wr_flag;
    logic        i2c_rd_flag;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_wr;
    logic        i2c_done;
    logic [7:0]  i2c_data_rd;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, i2c_done, i2c_data_rd,
        output gnt, done, err, rdata, busy,
               i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, i2c_done, i2c_data_rd,
        input  gnt, done, err, rdata, busy,
               i2c_start_flag, i2c_wr_flag, i2c_rd_flag, i2c_addr, i2c_data_wr
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM byte controller between two requesters,
// with completion timeout and a post-write hold-off while the EEPROM programs.
module i2c_arbiter #(
    parameter int WR_GAP_CYC  = 250000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic         clk,
    input logic         rstn,
    i2c_arbiter_if.slave bus
);
    localparam int CNT_MAX = (WR_GAP_CYC > TIMEOUT_CYC) ? WR_GAP_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(WR_GAP_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          wr_reg, wr_next;
    logic [15:0]   addr_reg, addr_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic [1:0]    done_reg, done_next;
    logic [1:0]    err_reg, err_next;

    logic [15:0]   addr_arr [2];
    logic [7:0]    wdata_arr [2];
    logic          winner;
    logic          active;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[16*gi +: 16];
            assign wdata_arr[gi] = bus.req_wdata[8*gi +: 8];
        end
    endgenerate

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    assign winner = (&bus.req) ? ~last_reg : bus.req[1];

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            owner_reg <= 1'b0;
            last_reg  <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        done_next  = '0;
        err_next   = '0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (|bus.req) begin
                    owner_next = winner;
                    last_next  = winner;
                    wr_next    = bus.req_wr[winner];
                    addr_next  = addr_arr[winner];
                    wdata_next = wdata_arr[winner];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A completion on the final timeout cycle still counts as success.
                if (bus.i2c_done) begin
                    done_next = 2'b01 << owner_reg;
                    cnt_next  = '0;
                    if (wr_reg) begin
                        state_next = GAP;
                    end else begin
                        rdata_next = bus.i2c_data_rd;
                        state_next = IDLE;
                    end
                end else if (cnt_reg == TO_LAST) begin
                    err_next   = 2'b01 << owner_reg;
                    cnt_next   = '0;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller-facing fields are only driven while a transaction is outstanding.
    assign active             = (state_reg == ISSUE) || (state_reg == WAIT);
    assign bus.gnt            = active ? (2'b01 << owner_reg) : 2'b00;
    assign bus.i2c_start_flag = (state_reg == ISSUE);
    assign bus.i2c_wr_flag    = active & wr_reg;
    assign bus.i2c_rd_flag    = active & ~wr_reg;
    assign bus.i2c_addr       = active ? addr_reg : 16'h0000;
    assign bus.i2c_data_wr    = active ? wdata_reg : 8'h00;
    assign bus.busy           = (state_reg != IDLE);
    assign bus.done           = done_reg;
    assign bus.err            = err_reg;
    assign bus.rdata          = rdata_reg;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: read, write + hold-off, round-robin tie,
// timeout, mid-WAIT reset and spurious controller completions.
module tb_i2c_arbiter;
    localparam int GAP = 8;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rstn;
    int   vectors = 0;
    int   miscompares = 0;

    i2c_arbiter_if ifc ();

    i2c_arbiter #(.WR_GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},   ifc.gnt, 2'b00);
        check({tag, "_busy"},  ifc.busy, 1'b0);
        check({tag, "_done"},  ifc.done, 2'b00);
        check({tag, "_err"},   ifc.err, 2'b00);
        check({tag, "_start"}, ifc.i2c_start_flag, 1'b0);
        check({tag, "_flags"}, {ifc.i2c_wr_flag, ifc.i2c_rd_flag}, 2'b00);
        check({tag, "_addr"},  ifc.i2c_addr, 16'h0000);
        check({tag, "_wdat"},  ifc.i2c_data_wr, 8'h00);
        check({tag, "_rdata"}, ifc.rdata, 8'h00);
    endtask

    initial begin
        rstn            = 1'b1;
        ifc.req         = 2'b00;
        ifc.req_wr      = 2'b00;
        ifc.req_addr    = 32'h0;
        ifc.req_wdata   = 16'h0;
        ifc.i2c_done    = 1'b0;
        ifc.i2c_data_rd = 8'h00;
        tick();
        tick();
        rstn = 1'b0;
        check_idle_outputs("reset");

        // Single read by requester 0
        ifc.req      = 2'b01;
        ifc.req_wr   = 2'b00;
        ifc.req_addr = 32'h0000_0010;
        tick();
        check("rd_issue_gnt",   ifc.gnt, 2'b01);
        check("rd_issue_start", ifc.i2c_start_flag, 1'b1);
        check("rd_issue_flags", {ifc.i2c_wr_flag, ifc.i2c_rd_flag}, 2'b01);
        check("rd_issue_addr",  ifc.i2c_addr, 16'h0010);
        check("rd_issue_busy",  ifc.busy, 1'b1);
        tick();
        check("rd_wait_start", ifc.i2c_start_flag, 1'b0);
        check("rd_wait_gnt",   ifc.gnt, 2'b01);
        check("rd_wait_flags", {ifc.i2c_wr_flag, ifc.i2c_rd_flag}, 2'b01);
        for (int i = 0; i < 19; i++) tick();
        check("rd_wait20_done", ifc.done, 2'b00);
        ifc.i2c_done    = 1'b1;
        ifc.i2c_data_rd = 8'hA5;
        tick();
        check("rd_done",  ifc.done, 2'b01);
        check("rd_rdata", ifc.rdata, 8'hA5);
        check("rd_gnt",   ifc.gnt, 2'b00);
        check("rd_busy",  ifc.busy, 1'b0);
        ifc.i2c_done = 1'b0;
        ifc.req      = 2'b00;
        tick();
        check("rd_done_clr", ifc.done, 2'b00);

        // Single write by requester 1, then hold-off with a spurious completion inside it
        ifc.req       = 2'b10;
        ifc.req_wr    = 2'b10;
        ifc.req_addr  = 32'h0123_0000;
        ifc.req_wdata = 16'h5C00;
        tick();
        check("wr_issue_gnt",   ifc.gnt, 2'b10);
        check("wr_issue_addr",  ifc.i2c_addr, 16'h0123);
        check("wr_issue_wdat",  ifc.i2c_data_wr, 8'h5C);
        check("wr_issue_flags", {ifc.i2c_wr_flag, ifc.i2c_rd_flag}, 2'b10);
        tick();
        tick();
        ifc.i2c_done    = 1'b1;
        ifc.i2c_data_rd = 8'h77;
        tick();
        check("wr_done",  ifc.done, 2'b10);
        check("wr_gnt",   ifc.gnt, 2'b00);
        check("wr_busy",  ifc.busy, 1'b1);
        check("wr_rdata", ifc.rdata, 8'hA5);
        check("wr_gap_addr", ifc.i2c_addr, 16'h0000);
        ifc.i2c_done = 1'b0;
        ifc.req      = 2'b00;
        tick();
        tick();
        ifc.i2c_done = 1'b1;
        tick();
        check("gap_spur_done", ifc.done, 2'b00);
        ifc.i2c_done = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("gap_last_busy", ifc.busy, 1'b1);
        tick();
        check("gap_end_busy", ifc.busy, 1'b0);

        // Spurious completion in IDLE
        ifc.i2c_done = 1'b1;
        tick();
        check("idle_spur_done", ifc.done, 2'b00);
        check("idle_spur_busy", ifc.busy, 1'b0);
        ifc.i2c_done = 1'b0;

        // Tie out of reset: 1, 0, 1
        rstn = 1'b1;
        tick();
        rstn          = 1'b0;
        ifc.req       = 2'b11;
        ifc.req_wr    = 2'b00;
        ifc.req_addr  = 32'h0BBB_0AAA;
        tick();
        check("tie1_gnt",  ifc.gnt, 2'b10);
        check("tie1_addr", ifc.i2c_addr, 16'h0BBB);
        tick();
        ifc.i2c_done = 1'b1;
        tick();
        check("tie1_done", ifc.done, 2'b10);
        check("tie1_gclr", ifc.gnt, 2'b00);
        ifc.i2c_done = 1'b0;
        tick();
        check("tie2_gnt",  ifc.gnt, 2'b01);
        check("tie2_addr", ifc.i2c_addr, 16'h0AAA);
        tick();
        ifc.i2c_done = 1'b1;
        tick();
        check("tie2_done", ifc.done, 2'b01);
        ifc.i2c_done = 1'b0;
        tick();
        check("tie3_gnt", ifc.gnt, 2'b10);
        tick();
        ifc.i2c_done = 1'b1;
        tick();
        check("tie3_done", ifc.done, 2'b10);
        ifc.i2c_done = 1'b0;
        ifc.req      = 2'b00;
        tick();

        // Timeout on requester 0 read
        ifc.req = 2'b01;
        tick();
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        check("to_last_wait_err", ifc.err, 2'b00);
        check("to_last_wait_gnt", ifc.gnt, 2'b01);
        tick();
        check("to_err",  ifc.err, 2'b01);
        check("to_done", ifc.done, 2'b00);
        check("to_gnt",  ifc.gnt, 2'b00);
        check("to_busy", ifc.busy, 1'b1);
        ifc.req = 2'b00;
        tick();
        check("to_err_clr", ifc.err, 2'b00);
        for (int i = 0; i < GAP - 2; i++) tick();
        check("to_gap_busy", ifc.busy, 1'b1);
        tick();
        check("to_gap_end", ifc.busy, 1'b0);

        // Reset in the middle of WAIT, then a normal read
        ifc.req      = 2'b10;
        ifc.req_wr   = 2'b00;
        tick();
        tick();
        tick();
        tick();
        rstn = 1'b1;
        ifc.req = 2'b00;
        ifc.i2c_done = 1'b1;
        tick();
        check_idle_outputs("rst_wait");
        rstn = 1'b0;
        ifc.i2c_done = 1'b0;
        ifc.req      = 2'b01;
        ifc.req_addr = 32'h0000_0042;
        tick();
        check("post_rst_gnt",  ifc.gnt, 2'b01);
        check("post_rst_addr", ifc.i2c_addr, 16'h0042);
        tick();
        ifc.i2c_done    = 1'b1;
        ifc.i2c_data_rd = 8'h3C;
        tick();
        check("post_rst_done",  ifc.done, 2'b01);
        check("post_rst_rdata", ifc.rdata, 8'h3C);
        ifc.i2c_done = 1'b0;
        ifc.req      = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
